// File: rtl/sram_reader.sv
// sram_reader: plays recorded 16-bit samples back from SRAM to the DAC.
// Fast mode skips samples, slow mode repeats or linearly interpolates them.
module sram_reader #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_play,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_interp,
  input  logic [2:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_dac_req,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic              o_read,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_done
);

  localparam int CW = DATA_W + 4;
  localparam logic signed [CW-1:0] MAX_V = CW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [CW-1:0] MIN_V = CW'(-(1 << (DATA_W - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_STOP, S_WAIT, S_PAUSE, S_FETCH, S_LATCH, S_CALC
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [2:0]               j_q, j_d;
  logic [3:0]               k_q, k_d;
  logic                     fast_q, fast_d;
  logic                     interp_q, interp_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic signed [DATA_W-1:0] data_q, data_d;

  logic signed [CW-1:0]     diff, prod, quot, sum;
  logic signed [DATA_W-1:0] sample;
  logic [ADDR_W:0]          nextAddr;
  logic                     groupEnd;
  logic                     pastEnd;

  // Sample value for the current sub-step: cur, or prev + (cur-prev)*j/k saturated
  always_comb begin
    diff = $signed({{4{cur_q[DATA_W-1]}}, cur_q}) - $signed({{4{prev_q[DATA_W-1]}}, prev_q});
    prod = diff * $signed({{(CW-3){1'b0}}, j_q});
    quot = prod / $signed({{(CW-4){1'b0}}, k_q});
    sum  = $signed({{4{prev_q[DATA_W-1]}}, prev_q}) + quot;
    if (fast_q || !interp_q || k_q == 4'd1) begin
      sample = cur_q;
    end else if (sum > MAX_V) begin
      sample = MAX_V[DATA_W-1:0];
    end else if (sum < MIN_V) begin
      sample = MIN_V[DATA_W-1:0];
    end else begin
      sample = sum[DATA_W-1:0];
    end
  end

  // Address that playback moves to once the current sample completes
  always_comb begin
    groupEnd = ({1'b0, j_q} == (k_q - 4'd1));
    if (fast_q) begin
      nextAddr = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, k_q};
    end else if (groupEnd) begin
      nextAddr = {1'b0, addr_q} + (ADDR_W+1)'(1);
    end else begin
      nextAddr = {1'b0, addr_q};
    end
    pastEnd = nextAddr[ADDR_W] || (nextAddr > {1'b0, i_end_addr});
  end

  // Next-state logic: enable and stop override every state, then per-state rules
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    j_d      = j_q;
    k_d      = k_q;
    fast_d   = fast_q;
    interp_d = interp_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    data_d   = data_q;
    o_valid  = 1'b0;
    if (!i_enable) begin
      state_d = S_IDLE;
    end else if (i_stop) begin
      state_d = S_STOP;
      addr_d  = '0;
      j_d     = '0;
      prev_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_STOP;
          addr_d  = '0;
          j_d     = '0;
          prev_d  = '0;
        end
        S_STOP: begin
          if (i_play) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (i_play) begin
            state_d = S_PAUSE;
          end else if (i_dac_req) begin
            if (j_q == 3'd0) begin
              k_d      = {1'b0, i_speed} + 4'd1;
              fast_d   = i_fast;
              interp_d = i_interp;
              state_d  = S_FETCH;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_PAUSE: begin
          if (i_play) state_d = S_WAIT;
        end
        S_FETCH: begin
          state_d = S_LATCH;
        end
        S_LATCH: begin
          cur_d   = $signed(i_sram_data);
          state_d = S_CALC;
        end
        S_CALC: begin
          o_valid = 1'b1;
          data_d  = sample;
          if (fast_q) begin
            j_d = '0;
          end else if (groupEnd) begin
            j_d    = '0;
            prev_d = cur_q;
          end else begin
            j_d = j_q + 3'd1;
          end
          if (pastEnd) begin
            state_d = S_STOP;
            addr_d  = '0;
            j_d     = '0;
            prev_d  = '0;
          end else begin
            state_d = S_WAIT;
            addr_d  = nextAddr[ADDR_W-1:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      j_q      <= '0;
      k_q      <= 4'd1;
      fast_q   <= 1'b0;
      interp_q <= 1'b0;
      prev_q   <= '0;
      cur_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      j_q      <= j_d;
      k_q      <= k_d;
      fast_q   <= fast_d;
      interp_q <= interp_d;
      prev_q   <= prev_d;
      cur_q    <= cur_d;
      data_q   <= data_d;
    end
  end

  assign o_read = (state_q == S_FETCH);
  assign o_done = (state_q == S_STOP);
  assign o_addr = addr_q;
  assign o_data = data_d;

endmodule

// File: tb/tb_sram_reader.sv
// tb_sram_reader: table-driven, hand-written and randomized checks of sram_reader
// against a sample-list playback model.
module tb_sram_reader;

  typedef struct {
    int newRun;
    int memSet;
    int fast;
    int interp;
    int speed;
    int endAddr;
    int expData;
    int expRead;
    int expRdAddr;
    int expDone;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_play = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_fast = 1'b0;
  logic        i_interp = 1'b0;
  logic [2:0]  i_speed = 3'd0;
  logic [19:0] i_end_addr = 20'd0;
  logic        i_dac_req = 1'b0;
  logic [15:0] sramData = 16'd0;
  logic        o_read, o_valid, o_done;
  logic [19:0] o_addr;
  logic [15:0] o_data;

  logic signed [15:0] mem [64];
  vec_t vecs [21];
  int total = 0;
  int bad = 0;

  sram_reader #(.ADDR_W(20), .DATA_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_play(i_play),
    .i_stop(i_stop), .i_fast(i_fast), .i_interp(i_interp), .i_speed(i_speed),
    .i_end_addr(i_end_addr), .i_dac_req(i_dac_req), .i_sram_data(sramData),
    .o_read(o_read), .o_addr(o_addr), .o_data(o_data), .o_valid(o_valid),
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // SRAM model: data for the strobed address appears the cycle after o_read
  always @(posedge i_clk) begin
    if (o_read) sramData <= mem[o_addr[5:0]];
  end

  // Overall time limit so a stuck design still terminates
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One request pulse, then watch up to 40 cycles for the answering o_valid
  task automatic applyStimulus(output logic signed [15:0] data, output int lat, output int reads,
                               output logic [19:0] rdAddr, output bit got);
    data = $signed(o_data);
    lat = 0;
    reads = 0;
    rdAddr = '0;
    got = 1'b0;
    @(negedge i_clk);
    i_dac_req = 1'b1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge i_clk);
      i_dac_req = 1'b0;
      if (o_read) begin
        reads++;
        rdAddr = o_addr;
      end
      if (o_valid) begin
        got = 1'b1;
        lat = c;
      end
      data = $signed(o_data);
    end
  endtask

  task automatic startRun(input bit fast, input bit interp, input logic [2:0] speed, input logic [19:0] endA);
    @(negedge i_clk);
    i_stop = 1'b1;
    i_fast = fast;
    i_interp = interp;
    i_speed = speed;
    i_end_addr = endA;
    @(negedge i_clk);
    i_stop = 1'b0;
    i_play = 1'b1;
    @(negedge i_clk);
    i_play = 1'b0;
  endtask

  task automatic loadMem(input int set);
    for (int a = 0; a < 64; a++) mem[a] = 16'sd0;
    case (set)
      0: begin mem[0] = 16'sd10; mem[1] = 16'sd20; mem[2] = 16'sd30; mem[3] = 16'sd40; end
      1: for (int a = 0; a < 6; a++) mem[a] = 16'(a + 1);
      2: begin mem[0] = 16'sd7; mem[1] = 16'sd9; end
      default: begin mem[0] = 16'sd100; mem[1] = -16'sd100; end
    endcase
  endtask

  // Abort a fetch in progress by stop (0), enable drop (1) or async reset mid-CALC (2)
  task automatic abortTest(input int kind);
    logic signed [15:0] d;
    int lat, reads, seen;
    logic [19:0] ra;
    bit got;
    loadMem(0);
    startRun(1'b0, 1'b0, 3'd0, 20'd3);
    applyStimulus(d, lat, reads, ra, got);
    checkOutput($sformatf("abort%0d_first", kind), d, 10);
    @(negedge i_clk);
    i_dac_req = 1'b1;
    @(negedge i_clk);
    i_dac_req = 1'b0;
    checkOutput($sformatf("abort%0d_read", kind), o_read, 1);
    @(negedge i_clk);
    if (kind == 0) begin
      i_stop = 1'b1;
    end else if (kind == 1) begin
      i_enable = 1'b0;
    end else begin
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      #1;
      checkOutput("abort2_rst_ctrl", {o_read, o_valid, o_done}, 0);
      checkOutput("abort2_rst_addr", o_addr, 0);
      checkOutput("abort2_rst_data", o_data, 0);
      #1 i_rst = 1'b1;
    end
    seen = 0;
    repeat (6) begin
      @(negedge i_clk);
      i_stop = 1'b0;
      if (o_valid || o_read) seen++;
    end
    checkOutput($sformatf("abort%0d_no_output", kind), seen, 0);
    if (kind == 1) begin
      checkOutput("abort1_idle_done", o_done, 0);
      i_enable = 1'b1;
      @(negedge i_clk);
    end else begin
      checkOutput($sformatf("abort%0d_done", kind), o_done, 1);
      checkOutput($sformatf("abort%0d_addr", kind), o_addr, 0);
    end
  endtask

  // Random playback compared with a list of samples built from the mode rules
  task automatic randomRun(input int r);
    bit fast, interp;
    int k, endA, prev, cur, v;
    int expQ[$];
    int rdQ[$];
    int posQ[$];
    logic signed [15:0] d;
    int lat, reads;
    logic [19:0] ra;
    bit got;
    fast = 1'($urandom_range(0, 1));
    interp = 1'($urandom_range(0, 1));
    k = $urandom_range(1, 8);
    endA = $urandom_range(0, 12);
    for (int a = 0; a < 64; a++) mem[a] = 16'($urandom());
    if (fast) begin
      for (int a = 0; a <= endA; a += k) begin
        expQ.push_back(int'(mem[a]));
        rdQ.push_back(1);
        posQ.push_back(0);
      end
    end else begin
      prev = 0;
      for (int a = 0; a <= endA; a++) begin
        cur = int'(mem[a]);
        for (int j = 0; j < k; j++) begin
          if (interp && k > 1) begin
            v = prev + ((cur - prev) * j) / k;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
          end else begin
            v = cur;
          end
          expQ.push_back(v);
          rdQ.push_back(j == 0 ? 1 : 0);
          posQ.push_back(j);
        end
        prev = cur;
      end
    end
    startRun(fast, interp, 3'(k - 1), 20'(endA));
    for (int i = 0; i < expQ.size(); i++) begin
      if (posQ[i] != 0) begin
        i_fast = 1'($urandom_range(0, 1));
        i_interp = 1'($urandom_range(0, 1));
        i_speed = 3'($urandom_range(0, 7));
      end else begin
        i_fast = fast;
        i_interp = interp;
        i_speed = 3'(k - 1);
      end
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      applyStimulus(d, lat, reads, ra, got);
      checkOutput($sformatf("rnd%0d_%0d_valid", r, i), got, 1);
      checkOutput($sformatf("rnd%0d_%0d_data", r, i), d, expQ[i]);
      checkOutput($sformatf("rnd%0d_%0d_reads", r, i), reads, rdQ[i]);
    end
    @(negedge i_clk);
    checkOutput($sformatf("rnd%0d_done", r), o_done, 1);
    checkOutput($sformatf("rnd%0d_addr", r), o_addr, 0);
  endtask

  initial begin
    logic signed [15:0] d;
    int lat, reads;
    logic [19:0] ra;
    bit got;

    // newRun, memSet, fast, interp, speed, endAddr, expData, expRead, expRdAddr, expDone
    vecs[0]  = '{1, 0, 0, 0, 0, 3, 10, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 3, 20, 1, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 3, 30, 1, 2, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 3, 40, 1, 3, 1};
    vecs[4]  = '{1, 1, 1, 0, 1, 5, 1, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, 0, 1, 5, 3, 1, 2, 0};
    vecs[6]  = '{0, 1, 1, 0, 1, 5, 5, 1, 4, 1};
    vecs[7]  = '{1, 2, 0, 0, 2, 1, 7, 1, 0, 0};
    vecs[8]  = '{0, 2, 0, 0, 2, 1, 7, 0, 0, 0};
    vecs[9]  = '{0, 2, 0, 0, 2, 1, 7, 0, 0, 0};
    vecs[10] = '{0, 2, 0, 0, 2, 1, 9, 1, 1, 0};
    vecs[11] = '{0, 2, 0, 0, 2, 1, 9, 0, 0, 0};
    vecs[12] = '{0, 2, 0, 0, 2, 1, 9, 0, 0, 1};
    vecs[13] = '{1, 3, 0, 1, 3, 1, 0, 1, 0, 0};
    vecs[14] = '{0, 3, 0, 1, 3, 1, 25, 0, 0, 0};
    vecs[15] = '{0, 3, 0, 1, 3, 1, 50, 0, 0, 0};
    vecs[16] = '{0, 3, 0, 1, 3, 1, 75, 0, 0, 0};
    vecs[17] = '{0, 3, 0, 1, 3, 1, 100, 1, 1, 0};
    vecs[18] = '{0, 3, 0, 1, 3, 1, 50, 0, 0, 0};
    vecs[19] = '{0, 3, 0, 1, 3, 1, 0, 0, 0, 0};
    vecs[20] = '{0, 3, 0, 1, 3, 1, -50, 0, 0, 1};

    loadMem(0);
    repeat (3) @(negedge i_clk);
    checkOutput("rst_ctrl", {o_read, o_valid, o_done}, 0);
    checkOutput("rst_addr", o_addr, 0);
    checkOutput("rst_data", o_data, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("idle_done", o_done, 0);
    i_enable = 1'b1;
    @(negedge i_clk);
    checkOutput("stop_done", o_done, 1);

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].newRun != 0) begin
        loadMem(vecs[i].memSet);
        startRun(vecs[i].fast[0], vecs[i].interp[0], 3'(vecs[i].speed), 20'(vecs[i].endAddr));
      end
      applyStimulus(d, lat, reads, ra, got);
      checkOutput($sformatf("vec%0d_valid", i), got, 1);
      checkOutput($sformatf("vec%0d_data", i), d, vecs[i].expData);
      checkOutput($sformatf("vec%0d_reads", i), reads, vecs[i].expRead);
      checkOutput($sformatf("vec%0d_lat32", i), (got && lat <= 32) ? 1 : 0, 1);
      if (vecs[i].expRead != 0) begin
        checkOutput($sformatf("vec%0d_rdaddr", i), ra, vecs[i].expRdAddr);
        if (vecs[i].interp == 0) checkOutput($sformatf("vec%0d_latency", i), lat, 3);
      end
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d_done", i), o_done, vecs[i].expDone);
      if (vecs[i].expDone != 0) checkOutput($sformatf("vec%0d_addr", i), o_addr, 0);
    end

    // Pause after two samples; requests while paused must be ignored
    loadMem(0);
    startRun(1'b0, 1'b0, 3'd0, 20'd3);
    applyStimulus(d, lat, reads, ra, got);
    checkOutput("pause_s0", d, 10);
    applyStimulus(d, lat, reads, ra, got);
    checkOutput("pause_s1", d, 20);
    @(negedge i_clk);
    i_play = 1'b1;
    @(negedge i_clk);
    i_play = 1'b0;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(d, lat, reads, ra, got);
      checkOutput($sformatf("pause_req%0d_valid", p), got, 0);
      checkOutput($sformatf("pause_req%0d_reads", p), reads, 0);
      checkOutput($sformatf("pause_req%0d_hold", p), d, 20);
    end
    @(negedge i_clk);
    i_play = 1'b1;
    @(negedge i_clk);
    i_play = 1'b0;
    applyStimulus(d, lat, reads, ra, got);
    checkOutput("resume_data", d, 30);
    checkOutput("resume_rdaddr", ra, 2);

    for (int kind = 0; kind < 3; kind++) abortTest(kind);

    for (int r = 0; r < 10; r++) randomRun(r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_reader.md
Name: sram_reader

Overview:
Playback-side counterpart of the recording SRAM writer. It reads 16-bit audio samples from external SRAM, starting at address 0 and ending at the last recorded address. Samples go to the DAC transmitter one per request. Variable speed: fast playback skips samples; slow playback holds each sample or interpolates linearly. Sits between the top-level play controller (SW/KEY) and the SRAM arbiter / DAC transmitter.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, sample width (signed two's complement)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_enable  in  1  level; playback mode selected (SW)
i_play  in  1  one-cycle pulse; start / pause / resume (KEY)
i_stop  in  1  one-cycle pulse; stop and rewind (KEY)
i_fast  in  1  1 = fast (skip), 0 = slow (repeat)
i_interp  in  1  slow mode only: 1 = linear interpolation, 0 = hold
i_speed  in  3  factor k = i_speed+1 (1..8)
i_end_addr  in  ADDR_W  last valid recorded address, inclusive
i_dac_req  in  1  one-cycle pulse from DAC transmitter requesting next sample
i_sram_data  in  DATA_W  SRAM read data, valid the cycle after o_read
o_read  out  1  one-cycle SRAM read strobe
o_addr  out  ADDR_W  SRAM read address (registered)
o_data  out  DATA_W  output sample; held between updates
o_valid  out  1  one-cycle pulse; o_data updated
o_done  out  1  high while in STOP

Behaviour:
- Reset: state IDLE; o_addr=0, o_read=0, o_data=0, o_valid=0, o_done=0; sub-counter j=0; prev=0; cur=0; k_r=1.
- States: IDLE, STOP, WAIT, PAUSE, FETCH, LATCH, CALC.
- Global priority, every state: !i_enable -> IDLE; else i_stop -> STOP with o_addr=0, j=0, prev=0; else per-state rules.
- IDLE: i_enable -> STOP, o_addr=0.
- STOP: o_done=1. i_play -> WAIT.
- WAIT: i_play -> PAUSE. i_dac_req with j==0 -> latch k_r from i_speed/i_fast/i_interp, then go to FETCH. i_dac_req with j!=0 -> CALC with no SRAM access. Mode inputs are sampled only at j==0, so a slow group always completes with its starting settings.
- PAUSE: i_play -> WAIT. i_dac_req is ignored. o_data holds its last value.
- FETCH: o_read=1 for exactly one cycle at the current o_addr -> LATCH.
- LATCH: cur <= i_sram_data -> CALC.
- CALC output:
  - fast mode or k_r==1: o_data = cur.
  - slow hold: o_data = cur.
  - slow interp: o_data = prev + ((cur-prev)*j)/k_r. Computed at DATA_W+4 bits. Signed division truncates toward zero. Result saturates to DATA_W.
- CALC completion: may take multiple cycles (sequential divider allowed). On completion o_valid pulses 1 cycle and the state returns to WAIT.
- Latency:
  - Fetch path without interpolation: i_dac_req at cycle t -> o_read at t+1, latch at t+2, o_valid at t+3.
  - Any path with interpolation: o_valid no later than t+32.
- Address advance on completion:
  - Fast: next = o_addr + k_r.
  - Slow: if j==k_r-1, then j=0, prev<=cur, next = o_addr+1; else j=j+1 and the address is unchanged.
  - Overflow check is done at ADDR_W+1 bits.
  - If next > i_end_addr or next > 2^ADDR_W-1: the sample just produced is still emitted, then -> STOP, o_addr=0, j=0, prev=0.
- i_dac_req arriving in FETCH/LATCH/CALC is dropped; it is not queued.
- Abort: i_stop or !i_enable during FETCH/LATCH/CALC cancels the pending output. No o_valid is produced. o_read is deasserted the next cycle.
- o_read is never high outside FETCH. o_addr changes only on CALC completion, stop/rewind, or IDLE->STOP.

Test Plan:
- 1x playback: SRAM[0..3]=10,20,30,40, i_end_addr=3, four requests -> o_data 10,20,30,40, each o_valid exactly 3 cycles after its request. After the fourth sample, o_done=1 and o_addr=0.
- Fast, i_speed=1 (k=2): SRAM[0..5]=1..6, i_end_addr=5 -> outputs 1,3,5, then STOP; read addresses are exactly 0,2,4.
- Slow hold, k=3: SRAM[0]=7, SRAM[1]=9 -> outputs 7,7,7,9,9,9. o_read occurs only on the 1st and 4th request.
- Slow interp, k=4: SRAM[0]=100, SRAM[1]=-100, prev=0 -> outputs 0,25,50,75, then 100,50,0,-50.
- Pause/resume: i_play after 2 samples, 3 requests while paused -> no o_read, no o_valid, o_data held. i_play again -> the next sample continues from the correct address.
- Abort: i_stop one cycle after o_read -> no o_valid, STOP, o_addr=0. Repeat with i_enable dropped -> IDLE. Repeat with an async reset mid-CALC -> all outputs are at reset values.
